// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM encoding and sizing helper for the sequenced ALU control.
// Imported by alu_control_seq and alu_cycle_counter.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_MUL = 4'h4;
    localparam logic [3:0] ALU_DIV = 4'h5;
    localparam logic [3:0] ALU_SLT = 4'h6;
    localparam logic [3:0] ALU_AND = 4'hD;
    localparam logic [3:0] ALU_SUB = 4'hE;
    localparam logic [3:0] ALU_ADD = 4'hF;

    localparam logic [3:0] EXEC_REG = 4'h0;
    localparam logic [3:0] EXEC_BR  = 4'h6;
    localparam logic [3:0] EXEC_LD  = 4'hE;
    localparam logic [3:0] EXEC_ST  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Result of decoding one request.
    typedef struct packed {
        logic [3:0] code;
        logic       illegal;
        logic       is_mul;
        logic       is_div;
    } dec_t;

    // Counter width able to hold max(mul, div) cycles.
    function automatic int cnt_width(input int mul, input int div);
        int m;
        m = (mul > div) ? mul : div;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/alu_cycle_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Ports: i_clk, i_rst, i_load/i_load_val (load), i_dec (decrement), o_zero.
module alu_cycle_counter
    import alu_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/alu_control_seq.sv
// Sequenced ALU control: decodes FUNC_CODE/EXECUTION, drives ALU enable for
// N cycles and reports completion over a valid/ready handshake.
// Ports: i_clk, i_rst (sync, active high), i_func_code, i_execution,
//   i_in_valid/o_in_ready (request), i_flush, o_alu_func_code, o_alu_en,
//   o_out_valid/i_out_ready (completion), o_illegal.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W     = 4,
    parameter int EXEC_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [FUNC_W-1:0] i_func_code,
    input  logic [EXEC_W-1:0] i_execution,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_flush,
    output logic [FUNC_W-1:0] o_alu_func_code,
    output logic              o_alu_en,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_illegal
);

    localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    function automatic dec_t decode(
        input logic [FUNC_W-1:0] f,
        input logic [EXEC_W-1:0] e
    );
        dec_t d;
        d = '0;
        if ((f >> 4) != '0) begin
            d.illegal = 1'b1;
        end else if (e == EXEC_W'(EXEC_REG)) begin
            case (f[3:0])
                ALU_NOP, ALU_MUL, ALU_DIV, ALU_SLT,
                ALU_AND, ALU_SUB, ALU_ADD: d.code = f[3:0];
                default:                   d.illegal = 1'b1;
            endcase
            d.is_mul = (f[3:0] == ALU_MUL);
            d.is_div = (f[3:0] == ALU_DIV);
        end else if (e == EXEC_W'(EXEC_LD) || e == EXEC_W'(EXEC_ST)) begin
            d.code = ALU_ADD;
        end else if (e == EXEC_W'(EXEC_BR)) begin
            d.code = ALU_SUB;
        end else begin
            d.code = e[3:0];
        end
        // Undefined ops run as inert single-cycle NOPs.
        if (d.illegal) begin
            d.code   = ALU_NOP;
            d.is_mul = 1'b0;
            d.is_div = 1'b0;
        end
        return d;
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [FUNC_W-1:0] r_func;
    logic              r_illegal;
    dec_t              w_dec;
    logic              w_accept;
    logic              w_zero;
    logic              w_dec_cnt;
    logic [CNT_W-1:0]  w_len_m1;

    assign w_dec    = decode(i_func_code, i_execution);
    assign w_accept = i_in_valid && o_in_ready;

    always_comb begin
        w_len_m1 = '0;
        if (w_dec.is_mul) begin
            w_len_m1 = CNT_W'(MUL_CYCLES - 1);
        end else if (w_dec.is_div) begin
            w_len_m1 = CNT_W'(DIV_CYCLES - 1);
        end
    end

    assign w_dec_cnt = (r_state == ST_EXEC) && !i_flush;

    alu_cycle_counter #(
        .W (CNT_W)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_load_val (w_len_m1),
        .i_dec      (w_dec_cnt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (i_flush)     w_next = ST_IDLE;
                else if (w_zero) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (i_flush)         w_next = ST_IDLE;
                else if (w_accept)   w_next = ST_EXEC;
                else if (i_out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Flush only blocks acceptance while an op is in flight.
    always_comb begin
        o_in_ready  = (r_state == ST_IDLE) ||
                      ((r_state == ST_DONE) && i_out_ready && !i_flush);
        o_alu_en    = (r_state == ST_EXEC) && !r_illegal;
        o_out_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_func    <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_func    <= FUNC_W'(w_dec.code);
            r_illegal <= w_dec.illegal;
        end
    end

    assign o_alu_func_code = r_func;
    assign o_illegal       = r_illegal;

endmodule
